// File: rtl/gate_sweep_pkg.sv
// rtl/gate_sweep_pkg.sv - shared encodings, FSM states and reference function for the gate sweep
package gate_sweep_pkg;

  // Expected gate function selected by the host
  typedef enum logic [1:0] {
    OP_OR  = 2'b00,
    OP_AND = 2'b01,
    OP_XOR = 2'b10,
    OP_NOR = 2'b11
  } op_t;

  // Sweep sequencer states
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    APPLY  = 3'd1,
    SETTLE = 3'd2,
    SAMPLE = 3'd3,
    HOLD   = 3'd4,
    DONE   = 3'd5
  } state_t;

  // Reference output of the gate for a given function and operand pair
  function automatic logic expected(input op_t op, input logic a, input logic b);
    logic y;
    case (op)
      OP_OR:   y = a | b;
      OP_AND:  y = a & b;
      OP_XOR:  y = a ^ b;
      default: y = ~(a | b);
    endcase
    return y;
  endfunction

endpackage

// File: rtl/gate_sweep_if.sv
// rtl/gate_sweep_if.sv - host and gate-facing signal bundle of the gate sweep controller
interface gate_sweep_if;
  logic       start;
  logic [1:0] op_sel;
  logic       gate_a;
  logic       gate_b;
  logic       gate_y;
  logic       busy;
  logic       result_valid;
  logic [1:0] result_idx;
  logic       result_y;
  logic       result_ok;
  logic       done;
  logic       pass;
  logic [2:0] fail_count;

  // Host side: issues start/op_sel and closes the loop through the gate
  modport master (
    output start, op_sel, gate_y,
    input  gate_a, gate_b, busy, result_valid, result_idx, result_y,
    input  result_ok, done, pass, fail_count
  );

  // Controller side
  modport slave (
    input  start, op_sel, gate_y,
    output gate_a, gate_b, busy, result_valid, result_idx, result_y,
    output result_ok, done, pass, fail_count
  );
endinterface

// File: rtl/gate_sweep_timer.sv
// rtl/gate_sweep_timer.sv - loadable down-counter with zero flag for settle and hold waits
module gate_sweep_timer #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             zero
);

  logic [CNT_W-1:0] cnt;

  // Load takes priority; decrement stops at zero so the flag stays asserted
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/gate_sweep_controller.sv
// rtl/gate_sweep_controller.sv - sequences a 2-input gate through its truth table and checks it
module gate_sweep_controller
  import gate_sweep_pkg::*;
#(
  parameter int SETTLE_CYC = 2,
  parameter int HOLD_CYC   = 10,
  parameter int CNT_W      = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  gate_sweep_if.slave bus
);

  // Timer reload values are one less than the wait length, since the zero
  // cycle itself is part of the wait
  localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE_CYC - 1);
  localparam logic [CNT_W-1:0] HOLD_LD   = CNT_W'((HOLD_CYC > 0) ? HOLD_CYC - 1 : 0);

  state_t     state;
  op_t        op_q;
  logic [1:0] idx;
  logic       gate_a_q;
  logic       gate_b_q;
  logic       busy_q;
  logic       result_valid_q;
  logic [1:0] result_idx_q;
  logic       result_y_q;
  logic       result_ok_q;
  logic       done_q;
  logic       pass_q;
  logic [2:0] fail_count_q;

  logic             t_load;
  logic [CNT_W-1:0] t_val;
  logic             t_dec;
  logic             t_zero;
  logic             vec_ok;

  // Compare against the registered operands, which are stable since APPLY
  assign vec_ok = (bus.gate_y == expected(op_q, gate_a_q, gate_b_q));

  // Timer is shared: loaded with the settle length in APPLY, with the hold
  // length in SAMPLE when another vector follows
  assign t_load = (state == APPLY) ||
                  ((state == SAMPLE) && (idx != 2'd3) && (HOLD_CYC != 0));
  assign t_val  = (state == APPLY) ? SETTLE_LD : HOLD_LD;
  assign t_dec  = (state == SETTLE) || (state == HOLD);

  gate_sweep_timer #(
    .CNT_W(CNT_W)
  ) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (t_load),
    .load_val(t_val),
    .dec     (t_dec),
    .zero    (t_zero)
  );

  // Sweep sequencer with registered outputs; pulses default low every cycle
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= IDLE;
      op_q           <= OP_OR;
      idx            <= 2'd0;
      gate_a_q       <= 1'b0;
      gate_b_q       <= 1'b0;
      busy_q         <= 1'b0;
      result_valid_q <= 1'b0;
      result_idx_q   <= 2'd0;
      result_y_q     <= 1'b0;
      result_ok_q    <= 1'b0;
      done_q         <= 1'b0;
      pass_q         <= 1'b0;
      fail_count_q   <= 3'd0;
    end else begin
      result_valid_q <= 1'b0;
      done_q         <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            op_q         <= op_t'(bus.op_sel);
            idx          <= 2'd0;
            fail_count_q <= 3'd0;
            pass_q       <= 1'b0;
            busy_q       <= 1'b1;
            state        <= APPLY;
          end
        end
        APPLY: begin
          // Order 11, 01, 10, 00
          gate_a_q <= ~idx[0];
          gate_b_q <= ~idx[1];
          state    <= SETTLE;
        end
        SETTLE: begin
          if (t_zero) state <= SAMPLE;
        end
        SAMPLE: begin
          result_valid_q <= 1'b1;
          result_idx_q   <= idx;
          result_y_q     <= bus.gate_y;
          result_ok_q    <= vec_ok;
          fail_count_q   <= fail_count_q + {2'b00, ~vec_ok};
          if (idx == 2'd3) begin
            state <= DONE;
          end else if (HOLD_CYC == 0) begin
            idx   <= idx + 2'd1;
            state <= APPLY;
          end else begin
            state <= HOLD;
          end
        end
        HOLD: begin
          if (t_zero) begin
            idx   <= idx + 2'd1;
            state <= APPLY;
          end
        end
        DONE: begin
          done_q <= 1'b1;
          pass_q <= (fail_count_q == 3'd0);
          busy_q <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          busy_q <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

  assign bus.gate_a       = gate_a_q;
  assign bus.gate_b       = gate_b_q;
  assign bus.busy         = busy_q;
  assign bus.result_valid = result_valid_q;
  assign bus.result_idx   = result_idx_q;
  assign bus.result_y     = result_y_q;
  assign bus.result_ok    = result_ok_q;
  assign bus.done         = done_q;
  assign bus.pass         = pass_q;
  assign bus.fail_count   = fail_count_q;

endmodule

// File: tb/tb_gate_sweep_controller.sv
// tb/tb_gate_sweep_controller.sv - directed self-checking bench for gate_sweep_controller
module tb_gate_sweep_controller;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;

  // Gate model for the default instance: 0 OR, 1 XOR, 2 stuck-0, 3 stuck-1
  int   gate_mode = 0;
  bit   sel = 1'b0;

  always #5 clk = ~clk;

  gate_sweep_if b0 ();
  gate_sweep_if b1 ();

  assign b0.gate_y = (gate_mode == 0) ? (b0.gate_a | b0.gate_b) :
                     (gate_mode == 1) ? (b0.gate_a ^ b0.gate_b) :
                     (gate_mode == 2) ? 1'b0 : 1'b1;
  assign b1.gate_y = b1.gate_a ^ b1.gate_b;

  gate_sweep_controller u0 (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (b0.slave)
  );

  gate_sweep_controller #(
    .SETTLE_CYC(1),
    .HOLD_CYC  (0),
    .CNT_W     (4)
  ) u1 (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (b1.slave)
  );

  // Observation mux over the two instances
  wire       m_valid = sel ? b1.result_valid : b0.result_valid;
  wire [1:0] m_idx   = sel ? b1.result_idx   : b0.result_idx;
  wire       m_y     = sel ? b1.result_y     : b0.result_y;
  wire       m_ok    = sel ? b1.result_ok    : b0.result_ok;
  wire       m_done  = sel ? b1.done         : b0.done;
  wire       m_pass  = sel ? b1.pass         : b0.pass;
  wire [2:0] m_fail  = sel ? b1.fail_count   : b0.fail_count;
  wire       m_busy  = sel ? b1.busy         : b0.busy;
  wire [1:0] m_ab    = sel ? {b1.gate_a, b1.gate_b} : {b0.gate_a, b0.gate_b};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_start(input logic v, input logic [1:0] op);
    if (sel) begin b1.start = v; b1.op_sel = op; end
    else     begin b0.start = v; b0.op_sel = op; end
  endtask

  // One full sweep; ey/eok bit n is the expectation for the n-th result
  task automatic sweep(input string name, input logic [1:0] op, input logic [3:0] ey,
                       input logic [3:0] eok, input int efail, input bit epass,
                       input int elat, input bit mid);
    int  n = 0;
    bit  got = 1'b0;
    @(negedge clk);
    set_start(1'b1, op);
    @(posedge clk);
    @(negedge clk);
    set_start(1'b0, op);
    chk({name, "_busy"}, 32'(m_busy), 32'd1);
    for (int k = 1; k <= 200 && !got; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (mid && k == 10) set_start(1'b1, 2'b00);
      if (mid && k == 11) set_start(1'b0, 2'b00);
      if (m_valid) begin
        chk({name, "_idx"}, 32'(m_idx), 32'(n));
        chk({name, "_y"},   32'(m_y),   32'(ey[n[1:0]]));
        chk({name, "_ok"},  32'(m_ok),  32'(eok[n[1:0]]));
        n++;
      end
      if (m_done) begin
        got = 1'b1;
        chk({name, "_latency"}, 32'(k), 32'(elat));
        chk({name, "_nres"},    32'(n), 32'd4);
        chk({name, "_fail"},    32'(m_fail), 32'(efail));
        chk({name, "_pass"},    32'(m_pass), 32'(epass));
        chk({name, "_busy_end"}, 32'(m_busy), 32'd0);
        chk({name, "_ab_end"},  32'(m_ab), 32'd0);
      end
    end
    if (!got) chk({name, "_timeout"}, 32'd0, 32'd1);
  endtask

  initial begin
    int  cnt;
    bit  seen;
    b0.start = 1'b0; b0.op_sel = 2'b00;
    b1.start = 1'b0; b1.op_sel = 2'b00;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_u0", {b0.busy, b0.done, b0.result_valid, b0.result_idx, b0.result_y,
                     b0.result_ok, b0.gate_a, b0.gate_b, b0.pass, b0.fail_count}, 32'd0);
    chk("reset_u1", {b1.busy, b1.done, b1.result_valid, b1.result_idx, b1.result_y,
                     b1.result_ok, b1.gate_a, b1.gate_b, b1.pass, b1.fail_count}, 32'd0);
    rst_n = 1'b1;

    // OR against OR gate
    sel = 1'b0; gate_mode = 0;
    sweep("or_or", 2'b00, 4'b0111, 4'b1111, 0, 1'b1, 47, 1'b0);
    @(negedge clk);
    chk("pass_held", 32'(b0.pass), 32'd1);

    // AND expected against OR gate
    sweep("and_or", 2'b01, 4'b0111, 4'b1001, 2, 1'b0, 47, 1'b0);

    // Restart attempt and op change mid-sweep are ignored
    sweep("mid_start", 2'b01, 4'b0111, 4'b1001, 2, 1'b0, 47, 1'b1);

    // Reset during HOLD of idx 2
    @(negedge clk);
    b0.start = 1'b1; b0.op_sel = 2'b01;
    @(posedge clk);
    @(negedge clk);
    b0.start = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 100 && !seen; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (b0.result_valid && b0.result_idx == 2'd2) seen = 1'b1;
    end
    chk("abort_reached_idx2", 32'(seen), 32'd1);
    chk("abort_pre_fail", 32'(b0.fail_count), 32'd2);
    chk("abort_pre_ab", 32'({b0.gate_a, b0.gate_b}), 32'b10);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    chk("abort_zero", {b0.busy, b0.done, b0.result_valid, b0.result_idx, b0.result_y,
                       b0.result_ok, b0.gate_a, b0.gate_b, b0.pass, b0.fail_count}, 32'd0);
    cnt = 0;
    for (int k = 0; k < 60; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (b0.done || b0.busy) cnt++;
    end
    chk("abort_no_done", 32'(cnt), 32'd0);
    sweep("after_abort", 2'b00, 4'b0111, 4'b1111, 0, 1'b1, 47, 1'b0);

    // Short-timing instance, XOR gate
    sel = 1'b1;
    sweep("xor_fast", 2'b10, 4'b0110, 4'b1111, 0, 1'b1, 13, 1'b0);

    // NOR expected, gate stuck at 0 and at 1
    sel = 1'b0; gate_mode = 2;
    sweep("nor_s0", 2'b11, 4'b0000, 4'b0111, 1, 1'b0, 47, 1'b0);
    gate_mode = 3;
    sweep("nor_s1", 2'b11, 4'b1111, 4'b1000, 3, 1'b0, 47, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
